// File: rtl/min_index_matrix_reduce_if.sv
// Bundles the set-input and result-output handshakes of the row-minimum
// reducer. The producer/consumer side uses master, the reducer uses slave.
interface min_index_matrix_reduce_if #(
    parameter int BITS       = 16,
    parameter int INDEX_BITS = 4,
    parameter int N          = 3,
    parameter int ROW_BITS   = 4
);
    logic                                in_valid;
    logic                                in_ready;
    logic [N-1:0][INDEX_BITS-1:0]        index;
    logic [N-1:0][BITS-1:0]              c;
    logic                                out_valid;
    logic                                out_ready;
    logic [ROW_BITS-1:0]                 row;
    logic [INDEX_BITS-1:0]               col;
    logic [BITS-1:0]                     value;

    modport master (
        output in_valid, index, c, out_ready,
        input  in_ready, out_valid, row, col, value
    );

    modport slave (
        input  in_valid, index, c, out_ready,
        output in_ready, out_valid, row, col, value
    );
endinterface

// File: rtl/min_index_matrix_reduce.sv
// Reduces N per-row (column index, minimum value) pairs to a single global
// minimum, scanning one row per clock with IEEE float ordering where NaN sorts
// above everything and -0 equals +0. Ties keep the lowest row.
module min_index_matrix_reduce #(
    parameter int    BITS       = 16,
    parameter string PRECISION  = "HALF",
    parameter int    INDEX_BITS = 4,
    parameter int    N          = 3,
    parameter int    ROW_BITS   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    min_index_matrix_reduce_if.slave  bus
);
    localparam int EXP_W = (PRECISION == "DOUBLE") ? 11 :
                           (PRECISION == "SINGLE") ? 8 : 5;
    localparam int MAN_W = BITS - 1 - EXP_W;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [ROW_BITS-1:0]     cnt_reg;
    logic [BITS-1:0]         c_reg   [N];
    logic [INDEX_BITS-1:0]   idx_reg [N];
    logic [ROW_BITS-1:0]     best_row_reg;
    logic [INDEX_BITS-1:0]   best_col_reg;
    logic [BITS-1:0]         best_val_reg;
    logic [BITS-1:0]         cur_c;
    logic [INDEX_BITS-1:0]   cur_idx;
    logic                    capture;

    // Strict "a < b" under float ordering; NaN is greater than any number
    // and equal to another NaN, signed zeros are equal.
    function automatic logic is_less(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        logic a_nan, b_nan, a_zero, b_zero;
        a_nan  = (&a[BITS-2 -: EXP_W]) && (|a[MAN_W-1:0]);
        b_nan  = (&b[BITS-2 -: EXP_W]) && (|b[MAN_W-1:0]);
        a_zero = ~|a[BITS-2:0];
        b_zero = ~|b[BITS-2:0];
        if (a_nan)
            return 1'b0;
        else if (b_nan)
            return 1'b1;
        else if (a_zero && b_zero)
            return 1'b0;
        else if (a[BITS-1] != b[BITS-1])
            return a[BITS-1];
        else if (a[BITS-1])
            return a[BITS-2:0] > b[BITS-2:0];
        else
            return a[BITS-2:0] < b[BITS-2:0];
    endfunction

    assign capture = (state_reg == IDLE) && bus.in_valid;

    // Capture every row's pair on the accepting edge; held otherwise.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cap
            always_ff @(posedge clk) begin
                if (capture) begin
                    c_reg[gi]   <= bus.c[gi];
                    idx_reg[gi] <= bus.index[gi];
                end
            end
        end
    endgenerate

    // Select the row currently being scanned.
    always_comb begin
        cur_c   = '0;
        cur_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_reg == ROW_BITS'(i)) begin
                cur_c   = c_reg[i];
                cur_idx = idx_reg[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic: single-row sets skip the scan entirely.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.in_valid) state_next = (N > 1) ? SCAN : DONE;
            SCAN: if (cnt_reg == ROW_BITS'(N - 1)) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Running best: seeded from row 0 on capture, replaced only on strict less.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            best_row_reg <= '0;
            best_col_reg <= '0;
            best_val_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        best_row_reg <= '0;
                        best_col_reg <= bus.index[0];
                        best_val_reg <= bus.c[0];
                        cnt_reg      <= ROW_BITS'(1);
                    end
                end
                SCAN: begin
                    if (is_less(cur_c, best_val_reg)) begin
                        best_row_reg <= cnt_reg;
                        best_col_reg <= cur_idx;
                        best_val_reg <= cur_c;
                    end
                    cnt_reg <= cnt_reg + ROW_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.row       = bus.out_valid ? best_row_reg : '0;
    assign bus.col       = bus.out_valid ? best_col_reg : '0;
    assign bus.value     = bus.out_valid ? best_val_reg : '0;
endmodule

// File: tb/tb_min_index_matrix_reduce.sv
// Bench for the row-minimum reducer (HALF, N=3): directed vectors with literal
// results, a reset-mid-scan case, backpressure, then random traffic, all also
// checked every cycle against a real-arithmetic reference model.
module tb_min_index_matrix_reduce;
    localparam int BITS       = 16;
    localparam int INDEX_BITS = 4;
    localparam int N          = 3;
    localparam int ROW_BITS   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    min_index_matrix_reduce_if #(.BITS(BITS), .INDEX_BITS(INDEX_BITS), .N(N), .ROW_BITS(ROW_BITS)) bus ();

    min_index_matrix_reduce #(
        .BITS(BITS), .PRECISION("HALF"), .INDEX_BITS(INDEX_BITS), .N(N), .ROW_BITS(ROW_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit h_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1f) && (h[9:0] != 10'd0);
    endfunction

    function automatic real h_real(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        if (e == 31)
            m = 1.0e300;
        else if (e == 0)
            m = real'(int'(h[9:0])) * (2.0 ** (-24));
        else
            m = real'(1024 + int'(h[9:0])) * (2.0 ** (e - 25));
        return h[15] ? -m : m;
    endfunction

    // First row holding the smallest value; NaN only wins if every row is NaN.
    function automatic int argmin(input logic [N-1:0][15:0] cv);
        int best;
        best = 0;
        for (int r = 1; r < N; r++) begin
            if (!h_nan(cv[r]) && (h_nan(cv[best]) || h_real(cv[r]) < h_real(cv[best])))
                best = r;
        end
        return best;
    endfunction

    typedef enum {PH_IDLE, PH_BUSY, PH_DONE} phase_t;
    phase_t                m_phase = PH_IDLE;
    int                    m_left  = 0;
    logic [ROW_BITS-1:0]   exp_row = '0;
    logic [INDEX_BITS-1:0] exp_col = '0;
    logic [BITS-1:0]       exp_val = '0;

    // Model: accept a set when idle, result appears N-1 edges later, released by out_ready.
    always @(posedge clk) begin
        int r;
        if (rst) begin
            m_phase = PH_IDLE;
        end else begin
            case (m_phase)
                PH_IDLE: if (bus.in_valid) begin
                    r       = argmin(bus.c);
                    exp_row = ROW_BITS'(r);
                    exp_col = bus.index[r];
                    exp_val = bus.c[r];
                    m_left  = N - 1;
                    m_phase = (m_left == 0) ? PH_DONE : PH_BUSY;
                end
                PH_BUSY: begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_DONE;
                end
                PH_DONE: if (bus.out_ready) m_phase = PH_IDLE;
                default: m_phase = PH_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit done;
        done = (m_phase == PH_DONE);
        check("in_ready",  64'(bus.in_ready),  64'(m_phase == PH_IDLE));
        check("out_valid", 64'(bus.out_valid), 64'(done));
        check("row",   64'(bus.row),   done ? 64'(exp_row) : 64'd0);
        check("col",   64'(bus.col),   done ? 64'(exp_col) : 64'd0);
        check("value", 64'(bus.value), done ? 64'(exp_val) : 64'd0);
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] rand_half();
        case ($urandom_range(0, 12))
            0:  return 16'h0000;
            1:  return 16'h8000;
            2:  return 16'h7C00;
            3:  return 16'hFC00;
            4:  return 16'h7E00;
            5:  return 16'hFE01;
            6:  return 16'h3C00;
            7:  return 16'hBC00;
            8:  return 16'h0001;
            9:  return 16'h8001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic scramble_inputs();
        for (int r = 0; r < N; r++) begin
            bus.c[r]     = rand_half();
            bus.index[r] = INDEX_BITS'($urandom);
        end
    endtask

    // Present one set, check latency and literal result; hold = apply 5 cycles of backpressure.
    task automatic run_set(input string name,
                           input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                           input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2,
                           input logic [3:0] e_row, input logic [3:0] e_col, input logic [15:0] e_val,
                           input bit hold);
        int k;
        logic [15:0] held_val;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check({name, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
        bus.out_ready = hold ? 1'b0 : 1'b1;
        bus.c         = {c2, c1, c0};
        bus.index     = {i2, i1, i0};
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        scramble_inputs();
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check({name, "_latency"}, 64'(k), 64'(N - 1));
        check({name, "_row"},   64'(bus.row),   64'(e_row));
        check({name, "_col"},   64'(bus.col),   64'(e_col));
        check({name, "_value"}, 64'(bus.value), 64'(e_val));
        if (hold) begin
            held_val     = bus.value;
            bus.in_valid = 1'b1;
            repeat (5) begin
                @(posedge clk); #1;
                scramble_inputs();
                check({name, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
                check({name, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
                check({name, "_hold_value"}, 64'(bus.value), 64'(held_val));
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({name, "_release"}, 64'(bus.in_ready), 64'd1);
        check({name, "_release_ov"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [N-1:0][15:0] pin_vec;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.c         = '0;
        bus.index     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_value",     64'(bus.value),     64'd0);
        rst = 1'b0;

        // Pin the model on hand-computed vectors.
        pin_vec = {16'h3C00, 16'hBC00, 16'h7E00};
        check("model_sign_nan", 64'(argmin(pin_vec)), 64'd1);
        pin_vec = {16'h7E00, 16'h7E00, 16'h7E00};
        check("model_all_nan", 64'(argmin(pin_vec)), 64'd0);
        pin_vec = {16'h3C00, 16'h0000, 16'h8000};
        check("model_zero_tie", 64'(argmin(pin_vec)), 64'd0);
        pin_vec = {16'h7C00, 16'h7E00, 16'hFC00};
        check("model_neg_inf", 64'(argmin(pin_vec)), 64'd0);

        run_set("basic",   16'h4000, 16'h3800, 16'h3C00, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 16'h3800, 1'b0);
        run_set("signnan", 16'h7E00, 16'hBC00, 16'h3C00, 4'd2, 4'd5, 4'd7, 4'd1, 4'd5, 16'hBC00, 1'b0);
        run_set("allnan",  16'h7E00, 16'h7E00, 16'h7E00, 4'd3, 4'd4, 4'd5, 4'd0, 4'd3, 16'h7E00, 1'b0);
        run_set("zeros",   16'h8000, 16'h0000, 16'h3C00, 4'd9, 4'd8, 4'd7, 4'd0, 4'd9, 16'h8000, 1'b0);
        run_set("ties",    16'h3C00, 16'h3C00, 16'h3C00, 4'd6, 4'd2, 4'd1, 4'd0, 4'd6, 16'h3C00, 1'b0);
        run_set("neginf",  16'h0001, 16'hFC00, 16'hC000, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 16'hFC00, 1'b0);
        run_set("lastrow", 16'h4000, 16'h3C00, 16'hB800, 4'd1, 4'd2, 4'd3, 4'd2, 4'd3, 16'hB800, 1'b0);
        run_set("backpr",  16'h3C00, 16'h4200, 16'h3400, 4'd4, 4'd5, 4'd6, 4'd2, 4'd6, 16'h3400, 1'b1);

        // Reset one cycle after capture discards the set.
        bus.c        = {16'h0000, 16'hBC00, 16'h3C00};
        bus.index    = '0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midscan_rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("midscan_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midscan_rst_value",     64'(bus.value),     64'd0);
        repeat (6) begin
            @(posedge clk); #1;
            check("midscan_rst_no_stale", 64'(bus.out_valid), 64'd0);
        end

        // Random traffic with sporadic resets and backpressure.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst           = ($urandom_range(0, 99) == 0);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            scramble_inputs();
            @(posedge clk); #1;
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/min_index_matrix_reduce.md
MIN_INDEX_MATRIX_REDUCE -- requirements
Module: min_index_matrix_reduce

Interface
REQ-001 SHALL have parameter BITS, default 16, element width in bits.
REQ-002 SHALL have parameter PRECISION, default "HALF", float format; legal values "HALF"/"SINGLE"/"DOUBLE", with BITS 16/32/64 and exponent widths 5/8/11 respectively.
REQ-003 SHALL have parameter INDEX_BITS, default 4, column index width.
REQ-004 SHALL have parameter N, default 3, number of rows, N >= 1.
REQ-005 SHALL have parameter ROW_BITS, default 4, row index width, 2^ROW_BITS >= N.
REQ-006 SHALL have clk  input  1  clock; all logic on its rising edge.
REQ-007 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have in_valid  input  1  per-row minima presented.
REQ-009 SHALL have in_ready  output  1  block can accept a new set.
REQ-010 SHALL have index  input  [INDEX_BITS-1:0] x N  per-row column index of row minimum.
REQ-011 SHALL have c  input  [BITS-1:0] x N  per-row minimum value.
REQ-012 SHALL have out_valid  output  1  global result held.
REQ-013 SHALL have out_ready  input  1  downstream accepts result.
REQ-014 SHALL have row  output  [ROW_BITS-1:0]  row of the global minimum.
REQ-015 SHALL have col  output  [INDEX_BITS-1:0]  column of the global minimum.
REQ-016 SHALL have value  output  [BITS-1:0]  global minimum value.

Function
REQ-017 SHALL implement FSM states IDLE, SCAN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-018 SHALL capture all N (index, c) pairs into internal registers on any edge with in_valid && in_ready; c/index SHALL be ignored at all other times.
REQ-019 On the capture edge, SHALL load best = row 0 (row=0, col=index[0], value=c[0]), then go to SCAN if N > 1, else to DONE.
REQ-020 In SCAN, SHALL compare exactly one captured row r per edge, r = 1..N-1 ascending; after the edge that processes r = N-1, SHALL go to DONE.
REQ-021 Latency: out_valid SHALL rise N-1 edges after the capture edge (e.g., N=3: 2 edges; N=1: immediately after the capture edge).
REQ-022 Compare SHALL use IEEE sign-magnitude ordering: negative < positive; among negatives, larger magnitude is smaller; among positives, smaller magnitude is smaller.
REQ-023 SHALL treat -0 and +0 as equal.
REQ-024 SHALL order NaN (exponent all ones, mantissa nonzero) above every non-NaN, including +inf; NaN compares equal to NaN.
REQ-025 Row r SHALL replace best only when strictly less, so ties keep the lowest row; if all rows are NaN, the result SHALL be row 0.
REQ-026 value SHALL be the captured bit pattern, unmodified (sign of zero preserved).
REQ-027 In DONE, row/col/value SHALL stay stable until out_valid && out_ready; on that edge the FSM SHALL go to IDLE. A new capture SHALL NOT occur on that same edge, since in_ready is low in DONE.
REQ-028 row/col/value SHALL be zero in IDLE and SCAN; they SHALL be valid only while out_valid is high.
REQ-029 out_ready SHALL be ignored outside DONE.

Reset
REQ-030 SHALL, on rst high at a clock edge, set state = IDLE, in_ready = 1, out_valid = 0, row/col/value = 0 and clear the scan counter, in all states.
REQ-031 rst SHALL take priority over simultaneous in_valid or out_ready; a reset mid-SCAN or in DONE SHALL discard the set with no output.

Verification
REQ-032 HALF, N=3: c = {0x4000, 0x3800, 0x3C00}, index = {1,0,1}, out_ready=1 -> out_valid 2 cycles after capture, row=1, col=0, value=0x3800, then in_ready=1.
REQ-033 Signs and NaN: c = {0x7E00, 0xBC00, 0x3C00} -> row=1, value=0xBC00; c = {0x7E00, 0x7E00, 0x7E00} -> row=0, value=0x7E00.
REQ-034 Ties and zeros: c = {0x8000, 0x0000, 0x3C00} -> row=0, value=0x8000; c = {0x3C00, 0x3C00, 0x3C00} -> row=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> one handshake, then IDLE; in_valid held high during DONE causes no capture.
REQ-036 rst asserted one cycle after capture (mid-SCAN) -> next cycle in_ready=1, out_valid=0, outputs 0; no stale result appears later.
